// File: rtl/stream_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// stream_rr_arbiter_if
//   Bundles the N requester-side valid/ready streams and the single shared
//   output stream of stream_rr_arbiter.
//
//   S_WVALID  [N]        per-requester valid
//   S_WREADY  [N]        per-requester ready (only the granted one can be 1)
//   S_WDATA   [N*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   S_WLAST   [N]        per-requester end-of-packet
//   M_WVALID / M_WREADY / M_WDATA / M_WLAST   shared output stream
//   M_WID     [ID_W]     index of the granted requester
//   GRANT_O   [N]        one-hot grant, 0 while idle
//
//   modport slave  : the arbiter's view
//   modport master : the surrounding logic (requesters + sink)
// ---------------------------------------------------------------------------
interface stream_rr_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int ID_W  = 2
);
   logic [N-1:0]       S_WVALID;
   logic [N-1:0]       S_WREADY;
   logic [N*WIDTH-1:0] S_WDATA;
   logic [N-1:0]       S_WLAST;
   logic               M_WVALID;
   logic               M_WREADY;
   logic [WIDTH-1:0]   M_WDATA;
   logic               M_WLAST;
   logic [ID_W-1:0]    M_WID;
   logic [N-1:0]       GRANT_O;

   modport slave (
      input  S_WVALID, S_WDATA, S_WLAST, M_WREADY,
      output S_WREADY, M_WVALID, M_WDATA, M_WLAST, M_WID, GRANT_O
   );

   modport master (
      output S_WVALID, S_WDATA, S_WLAST, M_WREADY,
      input  S_WREADY, M_WVALID, M_WDATA, M_WLAST, M_WID, GRANT_O
   );
endinterface

// File: rtl/stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// stream_rr_arbiter
//   N-to-1 packet-locked round-robin arbiter for valid/ready streams.
//   A grant is held until the granted requester's LAST beat, or until
//   MAX_BURST beats have passed in one grant (MAX_BURST = 0: no limit).
//   The final beat always carries M_WLAST so downstream packets are closed.
//   Datapath is a combinational mux; grant, rr pointer and beat count are
//   registered.
//
//   Ports:
//     CLK_I       clock
//     RST_I       asynchronous active-high reset
//     bus         stream_rr_arbiter_if.slave (requester streams, output
//                 stream, M_WID, GRANT_O)
//   Optional (macro STREAM_ARB_STATS_EN):
//     CNT_CLR_I   synchronous clear of the beat counters
//     BEAT_CNT_O  N x 16-bit saturating per-requester beat counters,
//                 requester i at [i*16 +: 16]
// ---------------------------------------------------------------------------
module stream_rr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int N         = 4,
   parameter int ID_W      = 2,
   parameter int MAX_BURST = 16
) (
   input  logic                   CLK_I,
   input  logic                   RST_I,
   stream_rr_arbiter_if.slave     bus
`ifdef STREAM_ARB_STATS_EN
   ,
   input  logic                   CNT_CLR_I,
   output logic [N*16-1:0]        BEAT_CNT_O
`endif
);

   localparam int         IDX_W     = (N > 1) ? $clog2(N) : 1;
   localparam bit         BURST_LIM = (MAX_BURST != 0);
   localparam logic [7:0] BURST_END = 8'(MAX_BURST - 1);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] g, g_nx;        // current grant index
   logic [IDX_W-1:0] last, last_nx;  // last served requester (rr pointer)
   logic [7:0]       bcnt, bcnt_nx;  // beats in the current grant

   logic [N-1:0]     g_onehot;
   logic             vld_g;
   logic             last_g;
   logic             burst_end;
   logic             beat;
   logic             final_beat;

   // Round-robin pick: scan ptr+1, ptr+2, ... wrapping at N; ptr itself is
   // looked at last, so it only wins when it is the sole requester.
   function automatic logic [IDX_W-1:0] arb(input logic [N-1:0]     req,
                                            input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] win;
      logic             found;
      int               idx;
      win   = '0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            win   = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   assign g_onehot = N'(1) << g;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state <= IDLE;
         g     <= '0;
         last  <= IDX_W'(N - 1);
         bcnt  <= '0;
      end else begin
         state <= state_nx;
         g     <= g_nx;
         last  <= last_nx;
         bcnt  <= bcnt_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      g_nx         = g;
      last_nx      = last;
      bcnt_nx      = bcnt;
      vld_g        = 1'b0;
      last_g       = 1'b0;
      burst_end    = 1'b0;
      beat         = 1'b0;
      final_beat   = 1'b0;
      bus.M_WVALID = 1'b0;
      bus.M_WDATA  = '0;
      bus.M_WLAST  = 1'b0;
      bus.M_WID    = '0;
      bus.GRANT_O  = '0;
      bus.S_WREADY = '0;

      case (state)
         IDLE: begin
            if (|bus.S_WVALID) begin
               g_nx     = arb(bus.S_WVALID, last);
               state_nx = LOCK;
               bcnt_nx  = '0;
            end
         end

         LOCK: begin
            vld_g        = bus.S_WVALID[g];
            last_g       = bus.S_WLAST[g];
            burst_end    = BURST_LIM && (bcnt == BURST_END);
            bus.M_WVALID = vld_g;
            bus.M_WDATA  = bus.S_WDATA[int'(g)*WIDTH +: WIDTH];
            bus.M_WLAST  = last_g | burst_end;
            bus.M_WID    = ID_W'(g);
            bus.GRANT_O  = g_onehot;
            bus.S_WREADY = bus.M_WREADY ? g_onehot : '0;

            beat       = vld_g & bus.M_WREADY;
            final_beat = beat & (last_g | burst_end);

            if (final_beat) begin
               // Rotate in the same cycle so a waiting requester gets the
               // very next beat; the pointer moves to g first so g is
               // considered last.
               last_nx = g;
               bcnt_nx = '0;
               if (|bus.S_WVALID) g_nx = arb(bus.S_WVALID, g);
               else               state_nx = IDLE;
            end else if (beat) begin
               bcnt_nx = bcnt + 8'd1;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

`ifdef STREAM_ARB_STATS_EN
   logic [N-1:0][15:0] beat_cnt;

   for (genvar i = 0; i < N; i++) begin : g_stat
      always_ff @(posedge CLK_I or posedge RST_I) begin
         if (RST_I)
            beat_cnt[i] <= '0;
         else if (CNT_CLR_I)
            beat_cnt[i] <= '0;
         else if (bus.S_WVALID[i] && bus.S_WREADY[i] && (beat_cnt[i] != 16'hFFFF))
            beat_cnt[i] <= beat_cnt[i] + 16'd1;
      end
   end

   assign BEAT_CNT_O = beat_cnt;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_rr_arbiter
//   Directed bench for stream_rr_arbiter (N=4, WIDTH=8, MAX_BURST=16).
//   Each requester is fed from its own beat queue; the expected output
//   beats {id,last,data} are written by hand into a scoreboard queue and a
//   monitor pops/compares them whenever the output handshakes.
//   Define STREAM_ARB_STATS_EN to also exercise the beat counters.
// ---------------------------------------------------------------------------
module tb_stream_rr_arbiter;
   localparam int WIDTH     = 8;
   localparam int N         = 4;
   localparam int ID_W      = 2;
   localparam int MAX_BURST = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stream_rr_arbiter_if #(.WIDTH(WIDTH), .N(N), .ID_W(ID_W)) bus ();

`ifdef STREAM_ARB_STATS_EN
   logic            cnt_clr = 1'b0;
   logic [N*16-1:0] beat_cnt;
`endif

   stream_rr_arbiter #(.WIDTH(WIDTH), .N(N), .ID_W(ID_W), .MAX_BURST(MAX_BURST)) dut (
      .CLK_I (clk),
      .RST_I (rst),
      .bus   (bus)
`ifdef STREAM_ARB_STATS_EN
      ,
      .CNT_CLR_I  (cnt_clr),
      .BEAT_CNT_O (beat_cnt)
`endif
   );

   logic [8:0]  rq [N][$];   // per-requester beats {last,data}
   logic [10:0] exq[$];      // expected output beats {id,last,data}
   int  nvec = 0;
   int  nerr = 0;
   bit  rdy_rand = 1'b0;
   bit  mon_en   = 1'b1;
   bit  stream1  = 1'b0;     // requester 1 streams endlessly (counter test)

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void src_beat(input int i, input bit lst, input int data);
      rq[i].push_back({lst, 8'(data)});
   endfunction

   function automatic void exp_beat(input int id, input bit lst, input int data);
      exq.push_back({2'(id), lst, 8'(data)});
   endfunction

   // Requester/sink driver: pops accepted beats and presents the next ones
   // 1 time unit after each rising edge.
   initial begin
      logic [N-1:0] fire;
      bus.S_WVALID = '0;
      bus.S_WDATA  = '0;
      bus.S_WLAST  = '0;
      bus.M_WREADY = 1'b0;
      forever begin
         @(negedge clk);
         fire = bus.S_WVALID & bus.S_WREADY;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (stream1 && i == 1) begin
               bus.S_WVALID[i] = 1'b1;
               bus.S_WLAST[i]  = 1'b0;
               bus.S_WDATA[i*WIDTH +: WIDTH] = 8'h5A;
            end else if (rq[i].size() > 0) begin
               bus.S_WVALID[i] = 1'b1;
               {bus.S_WLAST[i], bus.S_WDATA[i*WIDTH +: WIDTH]} = rq[i][0];
            end else begin
               bus.S_WVALID[i] = 1'b0;
               bus.S_WLAST[i]  = 1'b0;
               bus.S_WDATA[i*WIDTH +: WIDTH] = '0;
            end
         end
         bus.M_WREADY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compares every output beat, and every stalled cycle, against
   // the head of the scoreboard.
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && bus.M_WVALID) begin
            if (exq.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_beat: got id %0d data %0h, scoreboard empty at %0t",
                        bus.M_WID, bus.M_WDATA, $time);
            end else begin
               e = bus.M_WREADY ? exq.pop_front() : exq[0];
               check(bus.M_WREADY ? "beat_id"   : "stall_id",   32'(bus.M_WID),   32'(e[10:9]));
               check(bus.M_WREADY ? "beat_data" : "stall_data", 32'(bus.M_WDATA), 32'(e[7:0]));
               check(bus.M_WREADY ? "beat_last" : "stall_last", 32'(bus.M_WLAST), 32'(e[8]));
               check("grant_onehot", 32'(bus.GRANT_O), 32'(1) << e[10:9]);
            end
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_m_wvalid"}, 32'(bus.M_WVALID), 32'(0));
      check({tag, "_m_wdata"},  32'(bus.M_WDATA),  32'(0));
      check({tag, "_m_wlast"},  32'(bus.M_WLAST),  32'(0));
      check({tag, "_m_wid"},    32'(bus.M_WID),    32'(0));
      check({tag, "_grant"},    32'(bus.GRANT_O),  32'(0));
      check({tag, "_s_wready"}, 32'(bus.S_WREADY), 32'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) rq[i].delete();
      exq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int max_cyc);
      int n;
      n = 0;
      while (exq.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      nvec++;
      if (exq.size() != 0) begin
         nerr++;
         $display("FAIL %s_drain: %0d beats still expected after %0d cycles", tag, exq.size(), max_cyc);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
      $fatal(1);
   end

   initial begin
      int n;
      // ---- asynchronous reset, before any clock edge
      #2 rst = 1'b1;
      #1 check_outputs_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // ---- T1: single 3-beat packet from requester 0
      @(negedge clk);
      src_beat(0, 0, 8'h11); src_beat(0, 0, 8'h22); src_beat(0, 1, 8'h33);
      exp_beat(0, 0, 8'h11); exp_beat(0, 0, 8'h22); exp_beat(0, 1, 8'h33);
      @(negedge clk);                                   // valid just presented
      check("t1_arb_latency", 32'(bus.M_WVALID), 32'(0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t1_beat_valid", 32'(bus.M_WVALID), 32'(1));
      end
      @(negedge clk);
      check("t1_after_pkt", 32'(bus.M_WVALID), 32'(0));
      wait_drain("t1", 10);

      // ---- T2: all four requesters, 1-beat packets, rotation 0,1,2,3
      do_reset();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < N; i++) begin
            src_beat(i, 1, i*16 + k);
            exp_beat(i, 1, i*16 + k);
         end
      n = 0;
      while (!bus.M_WVALID && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("t2_first_grant", 32'(bus.M_WVALID), 32'(1));
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         check("t2_no_bubble", 32'(bus.M_WVALID), 32'(1));
      end
      wait_drain("t2", 20);

      // ---- T3: 40-beat packet from 2, forced release every 16 beats
      do_reset();
      for (int k = 0; k < 40; k++) src_beat(2, k == 39, k);
      src_beat(3, 0, 8'hA0); src_beat(3, 1, 8'hA1);
      for (int k = 0; k < 16; k++) exp_beat(2, k == 15, k);
      exp_beat(3, 0, 8'hA0); exp_beat(3, 1, 8'hA1);
      for (int k = 16; k < 32; k++) exp_beat(2, k == 31, k);
      for (int k = 32; k < 40; k++) exp_beat(2, k == 39, k);
      wait_drain("t3", 200);

      // ---- T4: random backpressure, requester 1 locked while 0 waits
      do_reset();
      rdy_rand = 1'b1;
      for (int k = 0; k < 6; k++) begin
         src_beat(1, k == 5, 8'h50 + k);
         exp_beat(1, k == 5, 8'h50 + k);
      end
      repeat (2) @(negedge clk);
      src_beat(0, 0, 8'h60); src_beat(0, 1, 8'h61);
      exp_beat(0, 0, 8'h60); exp_beat(0, 1, 8'h61);
      wait_drain("t4", 400);
      rdy_rand = 1'b0;

      // ---- T5: reset pulsed between edges in the middle of a packet
      do_reset();
      for (int k = 0; k < 5; k++) begin
         src_beat(0, k == 4, 8'h70 + k);
         exp_beat(0, k == 4, 8'h70 + k);
      end
      n = 0;
      while (exq.size() > 3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      #2;
      check("t5_mid_packet", 32'(bus.M_WVALID), 32'(1));
      rst = 1'b1;
      #1 check_outputs_zero("t5_reset");
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) rq[i].delete();
      exq.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         src_beat(i, 1, 8'h80 + i);
         exp_beat(i, 1, 8'h80 + i);
      end
      wait_drain("t5", 20);

`ifdef STREAM_ARB_STATS_EN
      // ---- T6: per-requester beat counters
      do_reset();
      for (int k = 0; k < 5; k++) begin
         src_beat(1, k == 4, k);
         exp_beat(1, k == 4, k);
      end
      wait_drain("t6", 20);
      repeat (2) @(negedge clk);
      check("t6_cnt1",     32'(beat_cnt[31:16]), 32'd5);
      check("t6_cnt0",     32'(beat_cnt[15:0]),  32'd0);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      @(negedge clk);
      check("t6_clr",      32'(beat_cnt[31:16]), 32'd0);
      mon_en  = 1'b0;
      stream1 = 1'b1;
      repeat (70000) @(negedge clk);
      check("t6_saturate", 32'(beat_cnt[31:16]), 32'hFFFF);
      stream1 = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
